mac_seq: RTL

//  Operand sequencer: the driving end of the MAC port (En/Clr/Ain/Bin in, Cout out).

---
 rtl/mac_seq_pkg.sv | 21 ++
 rtl/mac_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
//   Shared types and constants for the MAC operand sequencer.
//   state_t   : sequencer FSM states
//   DRAIN_CYC : cycles spent after the last En before Cout is captured
// -----------------------------------------------------------------------------
package mac_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      RESULT
   } state_t;

   // One cycle for the last registered En to reach the MAC, one more for the
   // accumulator register to show the final sum on Cout.
   localparam int DRAIN_CYC = 2;

endpackage : mac_seq_pkg

// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq
//   Operand sequencer driving one MAC (En/Clr/Ain/Bin in, Cout out). Per start
//   it clears the MAC, issues one En per accepted (a,b) pair until VEC_LEN
//   pairs have been taken, waits DRAIN_CYC cycles for the accumulate to settle,
//   captures Cout and offers it on a valid/ready result port.
//
//   Optional feature macro: MAC_SEQ_STALL_CNT_EN
//     Adds stall_cnt[15:0], a saturating count of FEED cycles with in_valid=0,
//     cleared in CLEAR.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin one dot product (sampled only in IDLE)
//   busy                  high in every state except IDLE
//   in_valid/in_ready     operand pair handshake, operands in_a/in_b
//   mac_clr/mac_en        MAC Clr / En (registered, never high together)
//   mac_a/mac_b           MAC Ain / Bin (registered, hold without handshake)
//   mac_cout              MAC Cout
//   res_valid/res_ready   result handshake, result on res_data
//   done                  one-cycle pulse after the result handshake
//   stall_cnt             (MAC_SEQ_STALL_CNT_EN only) FEED stall counter
// -----------------------------------------------------------------------------
module mac_seq
   import mac_seq_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int VEC_LEN    = 8,
   localparam int CNT_W      = $clog2(VEC_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
   output logic                    mac_clr,
   output logic                    mac_en,
   output logic [DATA_WIDTH-1:0]   mac_a,
   output logic [DATA_WIDTH-1:0]   mac_b,
   input  logic [3*DATA_WIDTH-1:0] mac_cout,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [3*DATA_WIDTH-1:0] res_data,
   output logic                    done
`ifdef MAC_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]             stall_cnt
`endif
);

   localparam int              DRW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(VEC_LEN - 1);
   localparam logic [DRW-1:0]  DRAIN_LAST = DRW'(DRAIN_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [DRW-1:0]   drain_cnt;
   logic             in_hs;

   // NOTE: in_ready and busy are plain continuous decodes of the state register;
   // continuous assigns cannot infer latches and keep the handshake zero-latency.
   assign in_ready = (state == FEED);
   assign busy     = (state != IDLE);
   assign in_hs    = in_valid & in_ready;

   // NOTE: all state and registered outputs use non-blocking assignments so that
   // every read in this block sees the value from the start of the cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         drain_cnt <= '0;
         mac_clr   <= 1'b0;
         mac_en    <= 1'b0;
         mac_a     <= '0;
         mac_b     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         done      <= 1'b0;
      end else begin
         // Strobes default low; only the states below raise them for one cycle.
         mac_clr <= 1'b0;
         mac_en  <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) state <= CLEAR;
            end
            CLEAR: begin
               mac_clr   <= 1'b1;
               count     <= '0;
               drain_cnt <= '0;
               state     <= FEED;
            end
            FEED: begin
               if (in_hs) begin
                  mac_a  <= in_a;
                  mac_b  <= in_b;
                  mac_en <= 1'b1;
                  count  <= count + CNT_W'(1);
                  if (count == LAST_IDX) state <= DRAIN;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + DRW'(1);
               if (drain_cnt == DRAIN_LAST) begin
                  res_data  <= mac_cout;
                  res_valid <= 1'b1;
                  state     <= RESULT;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MAC_SEQ_STALL_CNT_EN
   // Counts FEED cycles starved of operands; saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state == CLEAR) begin
         stall_cnt <= '0;
      end else if ((state == FEED) && !in_valid && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule : mac_seq
